// File: rtl/alu_operand_adder_pkg.sv
// Shared definitions for the EX-stage operand select and adder slice.
// Holds datapath width, operand-source encodings and the PC+4 constant.
package alu_operand_adder_pkg;

  localparam int XLEN = 64;

  localparam logic OP1_SRC_RS1 = 1'b0;
  localparam logic OP1_SRC_PC  = 1'b1;

  typedef enum logic [1:0] {
    OP2_SRC_RS2  = 2'd0,
    OP2_SRC_IMM  = 2'd1,
    OP2_SRC_FOUR = 2'd2,
    OP2_SRC_ZERO = 2'd3
  } op2_src_e;

  localparam logic [XLEN-1:0] CONST_FOUR = 64'd4;

endpackage

// File: rtl/alu_operand_adder_add64_core.sv
// Combinational 64-bit adder built as four 16-bit blocks with block-level
// carry lookahead; also derives the condition flags from the sum.
module add64_core
  import alu_operand_adder_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            overflow,
  output logic            sign,
  output logic            cout,
  output logic            carry,
  output logic            zero
);

  localparam int BLK  = 16;
  localparam int NBLK = XLEN / BLK;

  logic [NBLK:0]   blk_c;
  logic [NBLK-1:0] blk_g;
  logic [NBLK-1:0] blk_p;

  assign blk_c[0] = cin;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      logic [BLK:0]   raw_sum;
      logic [BLK-1:0] a_blk;
      logic [BLK-1:0] b_blk;

      assign a_blk   = a[gi*BLK +: BLK];
      assign b_blk   = b[gi*BLK +: BLK];
      assign raw_sum = {1'b0, a_blk} + {1'b0, b_blk};

      // Generate comes from the carry-free add; propagate only when every
      // bit toggles, so an incoming carry ripples through the whole block.
      assign blk_g[gi]     = raw_sum[BLK];
      assign blk_p[gi]     = &(a_blk ^ b_blk);
      assign blk_c[gi+1]   = blk_g[gi] | (blk_p[gi] & blk_c[gi]);
      assign sum[gi*BLK +: BLK] = raw_sum[BLK-1:0] + {{(BLK-1){1'b0}}, blk_c[gi]};
    end
  endgenerate

  assign cout     = blk_c[NBLK];
  assign carry    = ~blk_c[NBLK];
  assign sign     = sum[XLEN-1];
  assign zero     = (sum == '0);
  // b is already the effective (possibly inverted) operand, so this form
  // covers both add and subtract.
  assign overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

endmodule

// File: rtl/alu_operand_adder.sv
// EX-stage front end: picks ALU operands, adds or subtracts them and
// registers operands, sum and condition flags with one cycle of latency.
module alu_operand_adder
  import alu_operand_adder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            op1_src,
  input  logic [1:0]      op2_src,
  input  logic            sub,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            sign,
  output logic            cout,
  output logic            carry,
  output logic            zero
);

  logic [XLEN-1:0] op1_next;
  logic [XLEN-1:0] op2_next;
  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] sum_next;
  logic            overflow_next;
  logic            sign_next;
  logic            cout_next;
  logic            carry_next;
  logic            zero_next;

  logic [XLEN-1:0] op1_reg;
  logic [XLEN-1:0] op2_reg;
  logic [XLEN-1:0] result_reg;
  logic            overflow_reg;
  logic            sign_reg;
  logic            cout_reg;
  logic            carry_reg;
  logic            zero_reg;

  always_comb begin
    op1_next = (op1_src == OP1_SRC_PC) ? pc : rs1_data;
    op2_next = '0;
    case (op2_src_e'(op2_src))
      OP2_SRC_RS2:  op2_next = rs2_data;
      OP2_SRC_IMM:  op2_next = imm;
      OP2_SRC_FOUR: op2_next = CONST_FOUR;
      OP2_SRC_ZERO: op2_next = '0;
      default:      op2_next = '0;
    endcase
  end

  // Subtract is two's complement: invert op2 and inject a carry-in of 1.
  assign b_eff = sub ? ~op2_next : op2_next;

  add64_core u_core (
    .a        (op1_next),
    .b        (b_eff),
    .cin      (sub),
    .sum      (sum_next),
    .overflow (overflow_next),
    .sign     (sign_next),
    .cout     (cout_next),
    .carry    (carry_next),
    .zero     (zero_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op1_reg      <= '0;
      op2_reg      <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      sign_reg     <= 1'b0;
      cout_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      op1_reg      <= op1_next;
      op2_reg      <= op2_next;
      result_reg   <= sum_next;
      overflow_reg <= overflow_next;
      sign_reg     <= sign_next;
      cout_reg     <= cout_next;
      carry_reg    <= carry_next;
      zero_reg     <= zero_next;
    end
  end

  assign op1      = op1_reg;
  assign op2      = op2_reg;
  assign result   = result_reg;
  assign overflow = overflow_reg;
  assign sign     = sign_reg;
  assign cout     = cout_reg;
  assign carry    = carry_reg;
  assign zero     = zero_reg;

endmodule

// File: tb/tb_alu_operand_adder.sv
// Scoreboard bench for alu_operand_adder: expected results are queued as
// stimulus is driven and compared one cycle later when outputs update.
module tb_alu_operand_adder;

  logic        clk;
  logic        rst;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] pc;
  logic [63:0] imm;
  logic        op1_src;
  logic [1:0]  op2_src;
  logic        sub;
  logic [63:0] op1;
  logic [63:0] op2;
  logic [63:0] result;
  logic        overflow;
  logic        sign;
  logic        cout;
  logic        carry;
  logic        zero;

  int checks_cnt;
  int errors_cnt;

  typedef struct {
    string       tag;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] res;
    logic        ov;
    logic        sg;
    logic        co;
    logic        ca;
    logic        z;
  } exp_t;

  exp_t sb_q[$];

  alu_operand_adder dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .pc       (pc),
    .imm      (imm),
    .op1_src  (op1_src),
    .op2_src  (op2_src),
    .sub      (sub),
    .op1      (op1),
    .op2      (op2),
    .result   (result),
    .overflow (overflow),
    .sign     (sign),
    .cout     (cout),
    .carry    (carry),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Drive one operation, queue its expected outcome, then compare after the edge.
  task automatic apply(input string tag, input logic r, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [63:0] p, input logic [63:0] im,
                       input logic o1, input logic [1:0] o2, input logic s);
    exp_t        e;
    exp_t        got;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] wide;
    rst = r; rs1_data = r1; rs2_data = r2; pc = p; imm = im;
    op1_src = o1; op2_src = o2; sub = s;

    a = o1 ? p : r1;
    case (o2)
      2'd0:    b = r2;
      2'd1:    b = im;
      2'd2:    b = 64'd4;
      default: b = 64'd0;
    endcase
    e.tag = tag;
    if (r) begin
      e.op1 = '0; e.op2 = '0; e.res = '0;
      e.ov = 0; e.sg = 0; e.co = 0; e.ca = 0; e.z = 0;
    end else begin
      e.op1 = a;
      e.op2 = b;
      if (s) begin
        e.res = a - b;
        e.co  = (a >= b);
        e.ov  = (a[63] != b[63]) && (e.res[63] != a[63]);
      end else begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[63:0];
        e.co  = wide[64];
        e.ov  = (a[63] == b[63]) && (e.res[63] != a[63]);
      end
      e.sg = e.res[63];
      e.ca = !e.co;
      e.z  = (e.res == 64'd0);
    end
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      check_val({got.tag, "_op1"}, op1, got.op1);
      check_val({got.tag, "_op2"}, op2, got.op2);
      check_val({got.tag, "_result"}, result, got.res);
      check_val({got.tag, "_overflow"}, {63'd0, overflow}, {63'd0, got.ov});
      check_val({got.tag, "_sign"}, {63'd0, sign}, {63'd0, got.sg});
      check_val({got.tag, "_cout"}, {63'd0, cout}, {63'd0, got.co});
      check_val({got.tag, "_carry"}, {63'd0, carry}, {63'd0, got.ca});
      check_val({got.tag, "_zero"}, {63'd0, zero}, {63'd0, got.z});
      $display("txn %-12s rst=%0b res=%h ov=%0b sg=%0b co=%0b ca=%0b z=%0b",
               got.tag, rst, result, overflow, sign, cout, carry, zero);
    end
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1; rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
    op1_src = 1'b0; op2_src = 2'd0; sub = 1'b0;

    apply("reset", 1, 64'hDEAD_BEEF_0000_1111, 64'h5, 64'h1000, 64'h7, 1, 2'd1, 1);
    apply("add_imm", 0, 64'd5, 64'd0, 64'd0, 64'd3, 0, 2'd1, 0);
    apply("sub_neg", 0, 64'd3, 64'd5, 64'd0, 64'd0, 0, 2'd0, 1);
    apply("sub_equal", 0, 64'h1234, 64'h1234, 64'd0, 64'd0, 0, 2'd0, 1);
    apply("sub_zero", 0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 2'd0, 1);
    apply("add_ovf", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd1, 0, 2'd1, 0);
    apply("sub_ovf", 0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0, 0, 2'd0, 1);
    apply("pc_four", 0, 64'd9, 64'd9, 64'h8000_0000, 64'd9, 1, 2'd2, 0);
    apply("pc_zero", 0, 64'd9, 64'd9, 64'h8000_0000, 64'd9, 1, 2'd3, 0);
    apply("wrap", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd1, 0, 2'd1, 0);
    apply("mid_reset", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd1, 0, 2'd1, 1);
    apply("post_reset", 0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0000_0001_0001, 64'd0, 64'd0, 0, 2'd0, 0);
    // Block boundary carry chains: a full propagate run through 16-bit groups.
    apply("carry_chain", 0, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 0, 2'd0, 0);
    apply("borrow_chain", 0, 64'h0001_0000_0000_0000, 64'd1, 64'd0, 64'd0, 0, 2'd0, 1);

    for (int i = 0; i < 24; i++) begin
      apply("random", 0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
